// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates interrupts and the E-stage illegal-instruction
// exception, issues the ENTER/RETURN action pulses that flush the pipeline, redirect fetch
// and update mepc/mcause/mstatus.
module trap_ctrl #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VEC    = 32'h0000_0158,
  parameter int unsigned     SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ext_irq,
  input  logic            timer_irq,
  input  logic            sw_irq,
  input  logic            csr_meie,
  input  logic            csr_msie,
  input  logic            csr_mtie,
  input  logic            csr_mstatus_mie,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            validE,
  input  logic            stallE,
  input  logic [XLEN-1:0] pcE,
  input  logic            excp_illinstr,
  input  logic            mretE,
  output logic            excp_flush_pc_ena,
  output logic [XLEN-1:0] excp_flush_pc,
  output logic            csr_epc_we,
  output logic [XLEN-1:0] csr_epc_wdata,
  output logic            csr_mcause_we,
  output logic [XLEN-1:0] csr_mcause_wdata,
  output logic            csr_trap_enter,
  output logic            csr_trap_return,
  output logic            trap_busy
);

  typedef enum logic [0:0] {StIdle, StHandler} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_s;
  logic                   ext_en;
  logic                   sw_en;
  logic                   timer_en;
  logic                   irq_pend;
  logic                   go;
  logic                   take_irq;
  logic                   take_exc;
  logic                   take_ret;
  logic [XLEN-1:0]        irq_cause;

  assign ext_s = sync_q[SYNC_STAGES-1];

  // Synchronise the asynchronous external interrupt into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= ext_irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Interrupt gating, priority encoding and the decision-point qualifiers.
  always_comb begin
    ext_en    = ext_s & csr_meie;
    sw_en     = sw_irq & csr_msie;
    timer_en  = timer_irq & csr_mtie;
    irq_pend  = csr_mstatus_mie & (ext_en | sw_en | timer_en);
    // No decision while the flush we just issued is still in flight.
    go        = validE & ~stallE & ~excp_flush_pc_ena;
    take_irq  = go & irq_pend;
    take_exc  = go & ~irq_pend & excp_illinstr;
    take_ret  = go & ~irq_pend & ~excp_illinstr & mretE;
    irq_cause = '0;
    irq_cause[XLEN-1] = 1'b1;
    if (ext_en) begin
      irq_cause[3:0] = 4'd11;
    end else if (sw_en) begin
      irq_cause[3:0] = 4'd3;
    end else begin
      irq_cause[3:0] = 4'd7;
    end
  end

  // Trap FSM; every output is registered so each action lands one clk after the decision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= StIdle;
      excp_flush_pc_ena <= 1'b0;
      excp_flush_pc     <= '0;
      csr_epc_we        <= 1'b0;
      csr_epc_wdata     <= '0;
      csr_mcause_we     <= 1'b0;
      csr_mcause_wdata  <= '0;
      csr_trap_enter    <= 1'b0;
      csr_trap_return   <= 1'b0;
      trap_busy         <= 1'b0;
    end else begin
      excp_flush_pc_ena <= 1'b0;
      excp_flush_pc     <= '0;
      csr_epc_we        <= 1'b0;
      csr_epc_wdata     <= '0;
      csr_mcause_we     <= 1'b0;
      csr_mcause_wdata  <= '0;
      csr_trap_enter    <= 1'b0;
      csr_trap_return   <= 1'b0;
      if (take_irq || take_exc) begin
        // The E instruction is squashed and re-executes after mret, hence mepc = pcE.
        state_q           <= StHandler;
        excp_flush_pc_ena <= 1'b1;
        excp_flush_pc     <= TRAP_VEC;
        csr_epc_we        <= 1'b1;
        csr_epc_wdata     <= pcE;
        csr_mcause_we     <= 1'b1;
        csr_mcause_wdata  <= take_irq ? irq_cause : XLEN'(2);
        csr_trap_enter    <= 1'b1;
        trap_busy         <= 1'b1;
      end else if (take_ret) begin
        state_q           <= StIdle;
        excp_flush_pc_ena <= 1'b1;
        excp_flush_pc     <= csr_mepc;
        csr_trap_return   <= 1'b1;
        trap_busy         <= 1'b0;
      end else begin
        trap_busy         <= (state_q != StIdle);
      end
    end
  end

endmodule
